// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive dispatcher.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DST_MAC,
    ST_SRC_MAC,
    ST_ETH_TYPE,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_e;

  typedef enum logic {
    ROUTE_ARP = 1'b0,
    ROUTE_IP  = 1'b1
  } rx_route_e;

  localparam logic [47:0] BOARD_MAC_DEFAULT = 48'h00_11_22_33_44_55;
  localparam logic [47:0] MAC_BCAST         = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ETH_TYPE_ARP      = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;
  localparam logic [7:0]  SFD_BYTE          = 8'hD5;
  localparam int          PREAMBLE_MAX      = 7;
  localparam int          STRIP_DEPTH       = 5;

  function automatic logic mac_accept(input logic [47:0] dst, input logic [47:0] local_mac);
    return (dst == local_mac) || (dst == MAC_BCAST);
  endfunction

endpackage

// File: rtl/eth_rx_fcs_strip.sv
// Five-deep byte delay line: holds back the trailing FCS so the final
// payload byte can be tagged last when the frame ends.
module eth_rx_fcs_strip
  import eth_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] in_data,
  output logic       full,
  output logic       out_valid,
  output logic       out_last,
  output logic [7:0] out_data
);

  logic [7:0] pipe_q [STRIP_DEPTH];
  logic [7:0] pipe_d [STRIP_DEPTH];
  logic [2:0] fill_q, fill_d;

  assign full      = (fill_q == 3'(STRIP_DEPTH));
  assign out_valid = (push | flush) & full;
  assign out_last  = flush & full;
  assign out_data  = pipe_q[STRIP_DEPTH-1];

  always_comb begin
    pipe_d = pipe_q;
    fill_d = fill_q;
    if (flush) begin
      fill_d = '0;
    end else if (push) begin
      pipe_d[0] = in_data;
      for (int i = 1; i < STRIP_DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      if (!full) fill_d = fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int i = 0; i < STRIP_DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      fill_q <= fill_d;
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: rtl/eth_rx_dispatch.sv
// GMII receive front end: checks preamble/SFD, filters destination MAC,
// decodes EtherType and steers the FCS-stripped payload to ARP or IPv4.
//
// state     | meaning
// ----------+---------------------------------------------------------
// SYNC      | after reset, wait for dv=0 so a partial frame is ignored
// IDLE      | inter-frame gap, waiting for the first preamble byte
// PREAMBLE  | counting 0x55 bytes until the SFD
// DST_MAC   | shifting in destination MAC, filter on the sixth byte
// SRC_MAC   | shifting source MAC into the shadow register
// ETH_TYPE  | two EtherType bytes, selects route
// PAYLOAD   | streaming through the strip pipe to the routed port
// DROP      | rejected frame, wait for dv=0
module eth_rx_dispatch
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = BOARD_MAC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_valid,
  output logic [7:0]  arp_rx_data,
  output logic        arp_rx_last,
  output logic        ip_rx_valid,
  output logic [7:0]  ip_rx_data,
  output logic        ip_rx_last,
  output logic [47:0] src_mac,
  output logic [15:0] rx_drop_cnt
);

  rx_state_e   state_q, state_d;
  rx_route_e   route_q, route_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [39:0] dst_sh_q, dst_sh_d;
  logic [47:0] src_sh_q, src_sh_d;
  logic [7:0]  type_hi_q, type_hi_d;
  logic        first_q, first_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic        arp_valid_q, arp_valid_d, arp_last_q, arp_last_d;
  logic [7:0]  arp_data_q, arp_data_d;
  logic        ip_valid_q, ip_valid_d, ip_last_q, ip_last_d;
  logic [7:0]  ip_data_q, ip_data_d;

  logic        drop_inc, push, flush;
  logic        strip_full, strip_valid, strip_last;
  logic [7:0]  strip_data;
  logic        emit_arp, emit_ip;

  eth_rx_fcs_strip u_strip (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .flush     (flush),
    .in_data   (gmii_rxd),
    .full      (strip_full),
    .out_valid (strip_valid),
    .out_last  (strip_last),
    .out_data  (strip_data)
  );

  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    cnt_d     = cnt_q;
    dst_sh_d  = dst_sh_q;
    src_sh_d  = src_sh_q;
    type_hi_d = type_hi_q;
    first_d   = first_q;
    drop_inc  = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;

    // cnt_q is a down-counter of bytes remaining in the current field.
    case (state_q)
      ST_SYNC: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_d = ST_PREAMBLE;
            cnt_d   = 3'(PREAMBLE_MAX - 1);
          end else begin
            state_d  = ST_DROP;
            drop_inc = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d  = ST_IDLE;
          drop_inc = 1'b1;
        end else if (gmii_rxd == PREAMBLE_BYTE && cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_d = ST_DST_MAC;
          cnt_d   = 3'd5;
        end else begin
          state_d  = ST_DROP;
          drop_inc = 1'b1;
        end
      end
      ST_DST_MAC: begin
        if (!gmii_rx_dv) begin
          state_d  = ST_IDLE;
          drop_inc = 1'b1;
        end else begin
          dst_sh_d = {dst_sh_q[31:0], gmii_rxd};
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else if (mac_accept({dst_sh_q, gmii_rxd}, BOARD_MAC)) begin
            state_d = ST_SRC_MAC;
            cnt_d   = 3'd5;
          end else begin
            state_d  = ST_DROP;
            drop_inc = 1'b1;
          end
        end
      end
      ST_SRC_MAC: begin
        if (!gmii_rx_dv) begin
          state_d  = ST_IDLE;
          drop_inc = 1'b1;
        end else begin
          src_sh_d = {src_sh_q[39:0], gmii_rxd};
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            state_d = ST_ETH_TYPE;
            cnt_d   = 3'd1;
          end
        end
      end
      ST_ETH_TYPE: begin
        if (!gmii_rx_dv) begin
          state_d  = ST_IDLE;
          drop_inc = 1'b1;
        end else if (cnt_q != 3'd0) begin
          type_hi_d = gmii_rxd;
          cnt_d     = cnt_q - 3'd1;
        end else if ({type_hi_q, gmii_rxd} == ETH_TYPE_ARP) begin
          state_d = ST_PAYLOAD;
          route_d = ROUTE_ARP;
          first_d = 1'b1;
        end else if ({type_hi_q, gmii_rxd} == ETH_TYPE_IPV4) begin
          state_d = ST_PAYLOAD;
          route_d = ROUTE_IP;
          first_d = 1'b1;
        end else begin
          state_d  = ST_DROP;
          drop_inc = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (gmii_rx_dv) begin
          push = 1'b1;
        end else begin
          // A frame too short to fill the pipe carried no payload at all.
          flush   = 1'b1;
          state_d = ST_IDLE;
          if (!strip_full) drop_inc = 1'b1;
        end
      end
      ST_DROP: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase

    emit_arp    = strip_valid && (route_q == ROUTE_ARP);
    emit_ip     = strip_valid && (route_q == ROUTE_IP);
    arp_valid_d = emit_arp;
    arp_last_d  = emit_arp && strip_last;
    arp_data_d  = emit_arp ? strip_data : 8'h00;
    ip_valid_d  = emit_ip;
    ip_last_d   = emit_ip && strip_last;
    ip_data_d   = emit_ip ? strip_data : 8'h00;

    src_mac_d = src_mac_q;
    if (strip_valid && first_q) begin
      src_mac_d = src_sh_q;
      first_d   = 1'b0;
    end
    drop_cnt_d = drop_cnt_q + 16'(drop_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SYNC;
      route_q     <= ROUTE_ARP;
      cnt_q       <= '0;
      dst_sh_q    <= '0;
      src_sh_q    <= '0;
      type_hi_q   <= '0;
      first_q     <= 1'b0;
      drop_cnt_q  <= '0;
      src_mac_q   <= '0;
      arp_valid_q <= 1'b0;
      arp_last_q  <= 1'b0;
      arp_data_q  <= '0;
      ip_valid_q  <= 1'b0;
      ip_last_q   <= 1'b0;
      ip_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      cnt_q       <= cnt_d;
      dst_sh_q    <= dst_sh_d;
      src_sh_q    <= src_sh_d;
      type_hi_q   <= type_hi_d;
      first_q     <= first_d;
      drop_cnt_q  <= drop_cnt_d;
      src_mac_q   <= src_mac_d;
      arp_valid_q <= arp_valid_d;
      arp_last_q  <= arp_last_d;
      arp_data_q  <= arp_data_d;
      ip_valid_q  <= ip_valid_d;
      ip_last_q   <= ip_last_d;
      ip_data_q   <= ip_data_d;
    end
  end

  assign arp_rx_valid = arp_valid_q;
  assign arp_rx_data  = arp_data_q;
  assign arp_rx_last  = arp_last_q;
  assign ip_rx_valid  = ip_valid_q;
  assign ip_rx_data   = ip_data_q;
  assign ip_rx_last   = ip_last_q;
  assign src_mac      = src_mac_q;
  assign rx_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch: directed and random frames scored against a
// frame-level parsing model.
module tb_eth_rx_dispatch;

  localparam logic [47:0] TB_BOARD = 48'h00_11_22_33_44_55;
  localparam logic [47:0] TB_BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        arp_rx_valid, arp_rx_last, ip_rx_valid, ip_rx_last;
  logic [7:0]  arp_rx_data, ip_rx_data;
  logic [47:0] src_mac;
  logic [15:0] rx_drop_cnt;

  eth_rx_dispatch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .arp_rx_valid (arp_rx_valid),
    .arp_rx_data  (arp_rx_data),
    .arp_rx_last  (arp_rx_last),
    .ip_rx_valid  (ip_rx_valid),
    .ip_rx_data   (ip_rx_data),
    .ip_rx_last   (ip_rx_last),
    .src_mac      (src_mac),
    .rx_drop_cnt  (rx_drop_cnt)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       ip;
    logic [7:0] data;
    logic       last;
    int         cyc;
    logic       pre;
  } beat_t;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  logic [7:0]  frm[$];
  int          compared = 0;
  int          mismatched = 0;
  int          viol = 0;
  int          last_nbeats = 0;
  logic [15:0] exp_drop = '0;
  logic [47:0] exp_src = '0;
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      beat_t b;
      if (arp_rx_valid && ip_rx_valid) viol++;
      if ((arp_rx_last && !arp_rx_valid) || (ip_rx_last && !ip_rx_valid)) viol++;
      if (arp_rx_valid || ip_rx_valid) begin
        b.ip   = ip_rx_valid;
        b.data = ip_rx_valid ? ip_rx_data : arp_rx_data;
        b.last = ip_rx_valid ? ip_rx_last : arp_rx_last;
        b.cyc  = cyc;
        b.pre  = gmii_rx_dv && (gmii_rxd == 8'h55);
        obs_q.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic build(input int npre, input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et, input int nafter, input int trunc, input bit incr);
    frm.delete();
    repeat (npre) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int k = 5; k >= 0; k--) frm.push_back(dst[k*8 +: 8]);
    for (int k = 5; k >= 0; k--) frm.push_back(src[k*8 +: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int k = 0; k < nafter; k++) frm.push_back(incr ? 8'(k) : 8'($urandom));
    if (trunc >= 0) while (frm.size() > trunc) void'(frm.pop_back());
  endtask

  // Parse a whole frame as a byte list: returns where the payload starts
  // and how many bytes of it survive after the 4-byte FCS is removed.
  task automatic model(output bit drop, output int ps, output int np,
                       output logic ip, output logic [47:0] src);
    int n, h, len;
    logic [47:0] dst;
    logic [15:0] et;
    drop = 1'b1; ps = 0; np = 0; ip = 1'b0; src = '0; dst = '0;
    len = frm.size();
    n = 0;
    while (n < len && n < 8 && frm[n] == 8'h55) n++;
    if (n == 0 || n > 7 || n >= len) return;
    if (frm[n] != 8'hD5) return;
    h = n + 1;
    if (len < h + 14) return;
    for (int k = 0; k < 6; k++) begin
      dst = {dst[39:0], frm[h+k]};
      src = {src[39:0], frm[h+6+k]};
    end
    et = {frm[h+12], frm[h+13]};
    if (dst != TB_BOARD && dst != TB_BCAST) return;
    if (et == 16'h0806) ip = 1'b0;
    else if (et == 16'h0800) ip = 1'b1;
    else return;
    if (len - (h + 14) < 5) return;
    drop = 1'b0;
    ps = h + 14;
    np = len - ps - 4;
  endtask

  task automatic send(input int ifg, input int rel_idx);
    bit drop;
    int ps, np;
    logic ip;
    logic [47:0] src;
    beat_t b;
    model(drop, ps, np, ip, src);
    if (rel_idx < 0) begin
      if (drop) exp_drop++;
      else exp_src = src;
    end
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
      if (i == rel_idx) rst_n = 1'b1;
      if (rel_idx < 0 && !drop && i >= ps && i < ps + np) begin
        b.ip = ip; b.data = frm[i]; b.last = (i == ps + np - 1);
        b.cyc = cyc + 6; b.pre = 1'b0;
        exp_q.push_back(b);
      end
    end
    repeat (ifg) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    repeat (3) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b0;
    end
    last_nbeats = obs_q.size();
    chk({tag, "/beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "/beat{ip,data,last,cyc}"},
          64'({obs_q[i].ip, obs_q[i].data, obs_q[i].last, obs_q[i].cyc}),
          64'({exp_q[i].ip, exp_q[i].data, exp_q[i].last, exp_q[i].cyc}));
    end
    chk({tag, "/drop_cnt"}, 64'(rx_drop_cnt), 64'(exp_drop));
    chk({tag, "/src_mac"}, 64'(src_mac), 64'(exp_src));
    chk({tag, "/exclusive"}, 64'(viol), 64'(0));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic pre_seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/arp_valid", 64'(arp_rx_valid), 64'(0));
    chk("rst/ip_valid", 64'(ip_rx_valid), 64'(0));
    chk("rst/last", 64'({arp_rx_last, ip_rx_last}), 64'(0));
    chk("rst/data", 64'({arp_rx_data, ip_rx_data}), 64'(0));
    chk("rst/src_mac", 64'(src_mac), 64'(0));
    chk("rst/drop_cnt", 64'(rx_drop_cnt), 64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    build(7, TB_BOARD, 48'hA0A1A2A3A4A5, 16'h0806, 32, -1, 1'b1);
    send(12, -1);
    check_all("arp_uni");
    chk("arp_uni/nbeats", 64'(last_nbeats), 64'(28));
    chk("arp_uni/src", 64'(src_mac), 64'(48'hA0A1A2A3A4A5));

    build(7, TB_BCAST, rnd48(), 16'h0800, 50, -1, 1'b0);
    send(12, -1);
    check_all("ip_bcast");
    chk("ip_bcast/nbeats", 64'(last_nbeats), 64'(46));

    build(7, 48'h00_11_22_33_44_56, rnd48(), 16'h0806, 32, -1, 1'b1);
    send(4, -1);
    build(7, TB_BOARD, rnd48(), 16'h86DD, 32, -1, 1'b1);
    send(4, -1);
    check_all("filter");
    chk("filter/drop2", 64'(rx_drop_cnt), 64'(2));

    build(8, TB_BOARD, rnd48(), 16'h0806, 32, -1, 1'b1);
    send(3, -1);
    build(0, TB_BOARD, rnd48(), 16'h0806, 32, -1, 1'b1);
    send(3, -1);
    build(7, TB_BOARD, rnd48(), 16'h0806, 32, 11, 1'b1);
    send(3, -1);
    build(7, TB_BOARD, rnd48(), 16'h0806, 3, -1, 1'b1);
    send(3, -1);
    check_all("pre_err");
    chk("pre_err/drop6", 64'(rx_drop_cnt), 64'(6));

    build(7, TB_BOARD, 48'hC0C1C2C3C4C5, 16'h0806, 32, -1, 1'b1);
    send(1, -1);
    build(7, TB_BCAST, 48'hD0D1D2D3D4D5, 16'h0806, 20, -1, 1'b0);
    send(1, -1);
    pre_seen = 1'b0;
    foreach (obs_q[i]) begin
      if (obs_q[i].last) begin
        pre_seen = obs_q[i].pre;
        break;
      end
    end
    chk("b2b/last_with_preamble", 64'(pre_seen), 64'(1));
    check_all("b2b");

    build(7, TB_BOARD, 48'hB0B1B2B3B4B5, 16'h0806, 40, -1, 1'b1);
    mon_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
    end
    #1;
    chk("arst/valid_before", 64'(arp_rx_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst/valid", 64'(arp_rx_valid), 64'(0));
    chk("arst/drop_cnt", 64'(rx_drop_cnt), 64'(0));
    chk("arst/src_mac", 64'(src_mac), 64'(0));
    obs_q.delete();
    exp_q.delete();
    exp_drop = '0;
    exp_src  = '0;
    mon_en   = 1'b1;
    build(7, TB_BOARD, rnd48(), 16'h0806, 32, -1, 1'b1);
    send(3, 30);
    build(7, TB_BOARD, rnd48(), 16'h0800, 24, -1, 1'b0);
    send(4, -1);
    check_all("rst_release");

    for (int f = 0; f < 25; f++) begin
      int r, npre, nafter, trunc;
      logic [47:0] dst;
      logic [15:0] et;
      r = int'($urandom_range(0, 9));
      npre = (r > 8) ? 7 : r;
      case ($urandom_range(0, 3))
        0, 1:    dst = TB_BOARD;
        2:       dst = TB_BCAST;
        default: dst = rnd48();
      endcase
      case ($urandom_range(0, 2))
        0:       et = 16'h0806;
        1:       et = 16'h0800;
        default: et = 16'($urandom);
      endcase
      nafter = int'($urandom_range(0, 40));
      trunc  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : -1;
      build(npre, dst, rnd48(), et, nafter, trunc, 1'b0);
      send(int'($urandom_range(1, 4)), -1);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
